pipe_field: RTL and testbench

- Parametrised successor to the fixed four-pipe scroller used by the game top level.
- Holds NUM_PIPES obstacle columns and scrolls them left on a game-tick strobe, with selectable speed.
- Re-spawns off-screen pipes at pseudo-random gap heights from an internal LFSR.
- Counts score as the bird passes each pipe and produces a registered, sticky collision flag for the game FSM. Runs entirely on the system clock, gated by a one-cycle tick; it does not use derived clocks.

---
 rtl/pipe_field.sv | 179 +++++++++++++++++
 tb/tb_pipe_field.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_field.sv
// pipe_field: parametrised obstacle-column scroller for the game top level.
// Holds NUM_PIPES pipe columns that scroll left on each game tick. Pipes that
// leave the screen re-spawn at a pseudo-random gap height taken from an
// internal LFSR. The block also counts score as the bird passes each pipe,
// and raises a registered, sticky collision flag for the game FSM.
// Everything runs on clk and is gated by the one-cycle tick strobe.
module pipe_field #(
   parameter int          NUM_PIPES    = 4,
   parameter int          COORD_W      = 12,
   parameter int          SCREEN_W     = 640,
   parameter int          PIPE_W       = 60,
   parameter int          PIPE_SPACING = 200,
   parameter int          GAP_H        = 120,
   parameter int          GAP_MIN      = 60,
   parameter int          GAP_BITS     = 8,
   parameter int          STEP_BASE    = 2,
   parameter int          BIRD_W       = 54,
   parameter int          BIRD_H       = 36,
   parameter int          FLOOR_Y      = 440,
   parameter int          SCORE_W      = 10,
   parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           tick,
   input  logic                           run,
   input  logic                           restart,
   input  logic [1:0]                     speed_sel,
   input  logic signed [COORD_W-1:0]      bird_x,
   input  logic signed [COORD_W-1:0]      bird_y,
   output logic [NUM_PIPES*COORD_W-1:0]   pipe_x_bus,
   output logic [NUM_PIPES*COORD_W-1:0]   pipe_y_bus,
   output logic [SCORE_W-1:0]             score,
   output logic                           score_pulse,
   output logic                           collision
);

   // Two guard bits keep x - step, x + PIPE_W and wrap sums free of overflow.
   localparam int EXT_W  = COORD_W + 2;
   localparam int LFSR_W = 16;

   typedef logic signed [EXT_W-1:0] ext_t;

   localparam ext_t PIPE_W_EXT     = ext_t'(PIPE_W);
   localparam ext_t NEG_PIPE_W_EXT = ext_t'(-PIPE_W);
   localparam ext_t WRAP_SPAN_EXT  = ext_t'(NUM_PIPES * PIPE_SPACING);
   localparam ext_t BIRD_W_EXT     = ext_t'(BIRD_W);
   localparam ext_t BIRD_H_EXT     = ext_t'(BIRD_H);
   localparam ext_t GAP_H_EXT      = ext_t'(GAP_H);
   localparam ext_t FLOOR_EXT      = ext_t'(FLOOR_Y);
   localparam ext_t ZERO_EXT       = '0;

   // Gap-top used after reset: the middle of the random spawn range.
   localparam logic signed [COORD_W-1:0] RESET_GAP = COORD_W'(GAP_MIN + 2 ** (GAP_BITS - 1));
   localparam logic [SCORE_W-1:0]        SCORE_MAX = '1;

   // Registered state and its next-state values
   logic signed [COORD_W-1:0] pipe_x_reg  [NUM_PIPES];
   logic signed [COORD_W-1:0] pipe_x_next [NUM_PIPES];
   logic signed [COORD_W-1:0] pipe_y_reg  [NUM_PIPES];
   logic signed [COORD_W-1:0] pipe_y_next [NUM_PIPES];
   logic [LFSR_W-1:0]         lfsr_reg;
   logic [LFSR_W-1:0]         lfsr_next;
   logic [SCORE_W-1:0]        score_reg;
   logic [SCORE_W-1:0]        score_next;
   logic                      score_pulse_reg;
   logic                      score_pulse_next;
   logic                      collision_reg;
   logic                      collision_next;

   // Shared combinational terms
   logic                      scroll_en;
   ext_t                      step_ext;
   ext_t                      bird_x_ext;
   ext_t                      bird_y_ext;
   logic [NUM_PIPES-1:0]      pass_vec;
   logic [NUM_PIPES-1:0]      hit_vec;
   logic                      boundary_hit;

   // A scroll step only happens on a tick while playing; restart overrides it.
   assign scroll_en  = tick & run & ~restart;
   assign step_ext   = ext_t'(STEP_BASE * (int'(speed_sel) + 1));
   assign bird_x_ext = ext_t'(bird_x);
   assign bird_y_ext = ext_t'(bird_y);

   // Bird outside the playfield vertically: below the floor or above the top.
   assign boundary_hit = (bird_y_ext + BIRD_H_EXT > FLOOR_EXT) || (bird_y_ext < ZERO_EXT);

   // Fibonacci LFSR, taps 16,14,13,11 (bits 15,13,12,10).
   assign lfsr_next = {lfsr_reg[LFSR_W-2:0],
                       lfsr_reg[15] ^ lfsr_reg[13] ^ lfsr_reg[12] ^ lfsr_reg[10]};

   genvar gi;
   genvar gb;
   generate
      for (gi = 0; gi < NUM_PIPES; gi++) begin : g_pipe
         // Each pipe draws its spawn height from the LFSR rotated left by its
         // index, so pipes wrapping in the same cycle get different gaps.
         localparam int ROT = gi % LFSR_W;

         ext_t                x_ext;
         ext_t                y_ext;
         ext_t                nx_ext;
         logic                wrap;
         logic [GAP_BITS-1:0] gap_rand;

         for (gb = 0; gb < GAP_BITS; gb++) begin : g_gap_bit
            assign gap_rand[gb] = lfsr_reg[(gb - ROT + LFSR_W) % LFSR_W];
         end

         assign x_ext  = ext_t'(pipe_x_reg[gi]);
         assign y_ext  = ext_t'(pipe_y_reg[gi]);
         assign nx_ext = x_ext - step_ext;
         assign wrap   = (nx_ext <= NEG_PIPE_W_EXT);

         // The pipe's right edge crosses the bird's left edge on this step.
         assign pass_vec[gi] = scroll_en
                               && (x_ext + PIPE_W_EXT >= bird_x_ext)
                               && (nx_ext + PIPE_W_EXT < bird_x_ext);

         // Horizontal overlap with the column while not fully inside the gap.
         assign hit_vec[gi] = (bird_x_ext < x_ext + PIPE_W_EXT)
                              && (bird_x_ext + BIRD_W_EXT > x_ext)
                              && ((bird_y_ext < y_ext)
                                  || (bird_y_ext + BIRD_H_EXT > y_ext + GAP_H_EXT));

         assign pipe_x_next[gi] = !scroll_en ? pipe_x_reg[gi]
                                : wrap       ? COORD_W'(nx_ext + WRAP_SPAN_EXT)
                                :              COORD_W'(nx_ext);

         assign pipe_y_next[gi] = (scroll_en && wrap) ? COORD_W'(GAP_MIN + int'(gap_rand))
                                                      : pipe_y_reg[gi];

         assign pipe_x_bus[gi*COORD_W +: COORD_W] = pipe_x_reg[gi];
         assign pipe_y_bus[gi*COORD_W +: COORD_W] = pipe_y_reg[gi];
      end
   endgenerate

   // Score, score strobe and sticky collision next-state
   always_comb begin
      score_next       = score_reg;
      score_pulse_next = 1'b0;
      collision_next   = collision_reg | (|hit_vec) | boundary_hit;
      if (|pass_vec) begin
         score_pulse_next = 1'b1;
         if (score_reg != SCORE_MAX) begin
            score_next = score_reg + SCORE_W'(1);
         end
      end
   end

   // State register; rst and restart both return to the start-of-game state.
   always_ff @(posedge clk) begin
      if (rst || restart) begin
         for (int i = 0; i < NUM_PIPES; i++) begin
            pipe_x_reg[i] <= COORD_W'(SCREEN_W + i * PIPE_SPACING);
            pipe_y_reg[i] <= RESET_GAP;
         end
         lfsr_reg        <= LFSR_SEED;
         score_reg       <= '0;
         score_pulse_reg <= 1'b0;
         collision_reg   <= 1'b0;
      end else begin
         for (int i = 0; i < NUM_PIPES; i++) begin
            pipe_x_reg[i] <= pipe_x_next[i];
            pipe_y_reg[i] <= pipe_y_next[i];
         end
         lfsr_reg        <= lfsr_next;
         score_reg       <= score_next;
         score_pulse_reg <= score_pulse_next;
         collision_reg   <= collision_next;
      end
   end

   assign score       = score_reg;
   assign score_pulse = score_pulse_reg;
   assign collision   = collision_reg;

endmodule

// File: tb/tb_pipe_field.sv
// tb_pipe_field: directed and randomized checks of pipe_field against a
// behavioural game model. Two instances share stimulus: the default build and
// a SCORE_W=2 build used to observe score saturation.
module tb_pipe_field;
   localparam int CW = 12;
   localparam int NP = 4;

   logic                  clk = 1'b0;
   logic                  rst;
   logic                  tick;
   logic                  run;
   logic                  restart;
   logic [1:0]            speed_sel;
   logic signed [CW-1:0]  bird_x;
   logic signed [CW-1:0]  bird_y;

   logic [NP*CW-1:0]      px_bus;
   logic [NP*CW-1:0]      py_bus;
   logic [9:0]            score;
   logic                  score_pulse;
   logic                  collision;

   logic [NP*CW-1:0]      px_bus2;
   logic [NP*CW-1:0]      py_bus2;
   logic [1:0]            score2;
   logic                  score_pulse2;
   logic                  collision2;

   int vectors     = 0;
   int miscompares = 0;

   pipe_field dut (
      .clk(clk), .rst(rst), .tick(tick), .run(run), .restart(restart),
      .speed_sel(speed_sel), .bird_x(bird_x), .bird_y(bird_y),
      .pipe_x_bus(px_bus), .pipe_y_bus(py_bus), .score(score),
      .score_pulse(score_pulse), .collision(collision)
   );

   pipe_field #(.SCORE_W(2)) dut_small (
      .clk(clk), .rst(rst), .tick(tick), .run(run), .restart(restart),
      .speed_sel(speed_sel), .bird_x(bird_x), .bird_y(bird_y),
      .pipe_x_bus(px_bus2), .pipe_y_bus(py_bus2), .score(score2),
      .score_pulse(score_pulse2), .collision(collision2)
   );

   always #5 clk = ~clk;

   // ---------------- behavioural reference model ----------------
   int          m_x [NP];
   int          m_y [NP];
   int          m_passes;
   bit          m_pulse;
   bit          m_coll;
   logic [15:0] m_lfsr;

   function automatic logic [15:0] rotl16(input logic [15:0] v, input int n);
      return (v << n) | (v >> (16 - n));
   endfunction

   function automatic bit hits(input int px, input int py, input int bx, input int by);
      bit in_x, out_gap;
      in_x    = (bx < px + 60) && (bx + 54 > px);
      out_gap = (by < py) || (by + 36 > py + 120);
      return in_x && out_gap;
   endfunction

   task automatic model_init();
      for (int i = 0; i < NP; i++) begin
         m_x[i] = 640 + 200 * i;
         m_y[i] = 188;
      end
      m_passes = 0;
      m_pulse  = 1'b0;
      m_coll   = 1'b0;
      m_lfsr   = 16'hACE1;
   endtask

   initial model_init();

   // Model advances on the same edge the DUT does, from the same inputs.
   always @(posedge clk) begin
      int bx, by, step, nx;
      bit coll_now;
      if (rst || restart) begin
         model_init();
      end else begin
         bx = int'(bird_x);
         by = int'(bird_y);
         coll_now = (by + 36 > 440) || (by < 0);
         for (int i = 0; i < NP; i++) coll_now = coll_now | hits(m_x[i], m_y[i], bx, by);
         m_pulse = 1'b0;
         if (tick && run) begin
            step = 2 * (int'(speed_sel) + 1);
            for (int i = 0; i < NP; i++) begin
               nx = m_x[i] - step;
               if ((m_x[i] + 60 >= bx) && (nx + 60 < bx)) begin
                  m_passes++;
                  m_pulse = 1'b1;
               end
               if (nx <= -60) begin
                  m_x[i] = nx + 800;
                  m_y[i] = 60 + int'(rotl16(m_lfsr, i) & 16'h00FF);
               end else begin
                  m_x[i] = nx;
               end
            end
         end
         m_coll = m_coll | coll_now;
         m_lfsr = {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
      end
   end

   // ---------------- checking helpers ----------------
   function automatic logic signed [31:0] get_x(input int i);
      logic signed [CW-1:0] v;
      v = px_bus[i*CW +: CW];
      return v;
   endfunction

   function automatic logic signed [31:0] get_y(input int i);
      logic signed [CW-1:0] v;
      v = py_bus[i*CW +: CW];
      return v;
   endfunction

   function automatic int sat(input int v, input int mx);
      return (v > mx) ? mx : v;
   endfunction

   task automatic chk(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
      vectors++;
      assert (got === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
      end
   endtask

   task automatic check_model(input string tag);
      for (int i = 0; i < NP; i++) begin
         chk($sformatf("%s px%0d", tag, i), get_x(i), m_x[i]);
         chk($sformatf("%s py%0d", tag, i), get_y(i), m_y[i]);
      end
      chk({tag, " score"}, {22'd0, score}, sat(m_passes, 1023));
      chk({tag, " pulse"}, {31'd0, score_pulse}, {31'd0, m_pulse});
      chk({tag, " coll"}, {31'd0, collision}, {31'd0, m_coll});
      chk({tag, " score2"}, {30'd0, score2}, sat(m_passes, 3));
      chk({tag, " pulse2"}, {31'd0, score_pulse2}, {31'd0, m_pulse});
   endtask

   task automatic check_reset_state(input string tag);
      for (int i = 0; i < NP; i++) begin
         chk($sformatf("%s rst_px%0d", tag, i), get_x(i), 640 + 200 * i);
         chk($sformatf("%s rst_py%0d", tag, i), get_y(i), 188);
      end
      chk({tag, " rst_score"}, {22'd0, score}, 0);
      chk({tag, " rst_pulse"}, {31'd0, score_pulse}, 0);
      chk({tag, " rst_coll"}, {31'd0, collision}, 0);
   endtask

   // One clock with the currently driven inputs, then full model comparison.
   task automatic cycle_once(input string tag);
      @(posedge clk);
      @(negedge clk);
      check_model(tag);
   endtask

   task automatic do_restart(input string tag);
      restart = 1'b1;
      cycle_once(tag);
      restart = 1'b0;
   endtask

   int rbx, rby, guard;

   initial begin
      rst = 1'b1; tick = 1'b0; run = 1'b0; restart = 1'b0; speed_sel = 2'd0;
      bird_x = 12'sd150; bird_y = 12'sd200;
      @(negedge clk);
      @(negedge clk);
      check_reset_state("reset");
      rst = 1'b0;
      $display("step reset: pipes and flags at start values");

      // Scrolling at two speeds, then frozen by run=0
      run = 1'b1; tick = 1'b1;
      for (int n = 0; n < 10; n++) cycle_once("scroll0");
      chk("scroll10 px0", get_x(0), 620);
      speed_sel = 2'd3;
      cycle_once("scroll3");
      chk("speed3 px0", get_x(0), 612);
      speed_sel = 2'd0; run = 1'b0;
      for (int n = 0; n < 5; n++) cycle_once("frozen");
      chk("frozen px0", get_x(0), 612);
      $display("step scroll: px0 after speed 0/3 and freeze = %0d", get_x(0));

      // Restart mid-game after 50 moving ticks
      run = 1'b1;
      for (int n = 0; n < 39; n++) cycle_once("midgame");
      tick = 1'b0;
      do_restart("restart_mid");
      check_reset_state("restart_mid");
      $display("step restart mid-game: back to start values");

      // Score event at tick 276 with bird at (150,200)
      tick = 1'b1;
      for (int n = 1; n <= 277; n++) begin
         cycle_once("score_run");
         if (n == 275) begin
            chk("tick275 pulse", {31'd0, score_pulse}, 0);
            chk("tick275 score", {22'd0, score}, 0);
         end
         if (n == 276) begin
            chk("tick276 pulse", {31'd0, score_pulse}, 1);
            chk("tick276 score", {22'd0, score}, 1);
            chk("tick276 px0", get_x(0), 88);
         end
      end
      chk("score_run coll", {31'd0, collision}, 0);
      $display("step score: score=%0d after 277 ticks", score);

      // Collision cases
      tick = 1'b0;
      do_restart("restart_coll");
      tick = 1'b1;
      for (int n = 0; n < 260; n++) cycle_once("coll_approach");
      tick = 1'b0;
      chk("coll_approach px0", get_x(0), 120);
      bird_y = 12'sd50;
      cycle_once("coll_hit");
      chk("coll_hit", {31'd0, collision}, 1);
      bird_y = 12'sd200;
      cycle_once("coll_sticky");
      chk("coll_sticky", {31'd0, collision}, 1);
      do_restart("coll_clear");
      chk("coll_clear", {31'd0, collision}, 0);
      cycle_once("coll_gap");
      chk("coll_gap", {31'd0, collision}, 0);
      bird_y = 12'sd410;
      cycle_once("coll_floor");
      chk("coll_floor", {31'd0, collision}, 1);
      bird_y = 12'sd200;
      $display("step collision: pipe, sticky, clear, gap and floor cases done");

      // Wrap of pipe 0 from -58
      do_restart("restart_wrap");
      tick = 1'b1;
      for (int n = 0; n < 349; n++) cycle_once("wrap_approach");
      chk("wrap_pre px0", get_x(0), -58);
      cycle_once("wrap");
      chk("wrap px0", get_x(0), 740);
      chk("wrap py0 in range", {31'd0, (get_y(0) >= 60) && (get_y(0) <= 315)}, 1);
      chk("wrap px1", get_x(1), 140);
      $display("step wrap: px0=%0d py0=%0d", get_x(0), get_y(0));

      // Restart and tick in the same cycle
      tick = 1'b1;
      do_restart("restart_tick");
      check_reset_state("restart_tick");
      $display("step restart+tick: start values");

      // Saturation in the SCORE_W=2 build
      speed_sel = 2'd3; run = 1'b1; tick = 1'b1;
      guard = 0;
      while (m_passes < 5 && guard < 400) begin
         cycle_once("sat_run");
         if (m_pulse && m_passes == 4) begin
            chk("sat4 score2", {30'd0, score2}, 3);
            chk("sat4 pulse2", {31'd0, score_pulse2}, 1);
         end
         guard++;
      end
      if (guard >= 400) begin
         miscompares++;
         $error("FAIL sat_timeout observed passes=%0d expected>=5", m_passes);
      end
      $display("step saturation: score2=%0d after %0d passes", score2, m_passes);

      // Randomized play
      for (int n = 0; n < 2000; n++) begin
         tick      = ($urandom_range(0, 2) != 0);
         run       = ($urandom_range(0, 9) != 0);
         speed_sel = 2'($urandom_range(0, 3));
         restart   = ($urandom_range(0, 399) == 0);
         if ($urandom_range(0, 15) == 0) begin
            rbx = int'($urandom_range(0, 800)) - 100;
            rby = int'($urandom_range(0, 500)) - 30;
            bird_x = rbx[CW-1:0];
            bird_y = rby[CW-1:0];
         end
         cycle_once("random");
      end
      restart = 1'b0;
      $display("step random: 2000 cycles, passes=%0d", m_passes);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
